// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for a 5-stage RISC-V pipeline, including the data-memory wait/timeout FSM.
// Optional perf counters are enabled with `define PIPE_CTRL_PERF_EN.

module pipe_hazard_fwd_sel (
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_regwrite,
    output logic [1:0] o_sel
);
    logic w_hit_mem;
    logic w_hit_wb;

    // x0 is hardwired zero, so it is never a forwarding source
    assign w_hit_mem = i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs);
    assign w_hit_wb  = i_wb_regwrite  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_ex_rs);

    always_comb begin
        o_sel = 2'b00;
        if (w_hit_mem)
            o_sel = 2'b10;
        else if (w_hit_wb)
            o_sel = 2'b01;
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_redirect,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       mem_access,
    input  logic       dmem_ready,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       exmem_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_lu_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || PERF_W < 1) begin : g_bad_param
        $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 1..255 and PERF_W >= 1");
    end

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MWAIT = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_mem_err;
    logic       w_mem_stall;
    logic       w_err_set;
    logic       w_err_drop;
    logic       w_load_use;
    logic       w_lu_act;
    logic       w_redir_act;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_RUN;
            r_cnt     <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= w_err_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_stall = 1'b0;
        w_err_set   = 1'b0;
        w_err_drop  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (mem_access && !dmem_ready) begin
                    w_mem_stall = 1'b1;
                    w_state_nxt = S_MWAIT;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_MWAIT: begin
                if (dmem_ready) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt < TMO) begin
                    w_mem_stall = 1'b1;
                    w_cnt_nxt   = r_cnt + 8'd1;
                end else begin
                    w_mem_stall = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = S_ERR;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_ERR: begin
                // Timed-out access is dropped; any late ready is ignored
                w_err_drop  = 1'b1;
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 8'd0;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // A frozen EX keeps its redirect, so it only acts once memory releases
    assign w_redir_act = ex_redirect && !w_mem_stall;
    assign w_lu_act    = w_load_use && !w_mem_stall && !ex_redirect;

    logic [1:0][4:0] w_ex_rs;
    logic [1:0][1:0] w_fwd;

    assign w_ex_rs = {ex_rs2, ex_rs1};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        pipe_hazard_fwd_sel u_fwd (
            .i_ex_rs        (w_ex_rs[g]),
            .i_mem_rd       (mem_rd),
            .i_mem_regwrite (mem_regwrite),
            .i_wb_rd        (wb_rd),
            .i_wb_regwrite  (wb_regwrite),
            .o_sel          (w_fwd[g])
        );
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rstn) begin
            fwd_a = w_fwd[0];
            fwd_b = w_fwd[1];
            if (w_mem_stall) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else begin
                memwb_flush = w_err_drop;
                if (w_redir_act) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (w_lu_act) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    assign mem_err = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_lu;
    logic [PERF_W-1:0] r_perf_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_stall <= '0;
            r_perf_lu    <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_mem_stall) r_perf_stall <= r_perf_stall + 1'b1;
            if (w_lu_act)    r_perf_lu    <= r_perf_lu + 1'b1;
            if (w_redir_act) r_perf_flush <= r_perf_flush + 1'b1;
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_lu_cnt    = r_perf_lu;
    assign perf_flush_cnt = r_perf_flush;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, redirect, forwarding, memory wait, timeout and async reset.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
    logic       mem_regwrite, mem_access, dmem_ready, wb_regwrite;
    logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic       ifid_flush, idex_flush, memwb_flush, mem_err;
    logic [1:0] fwd_a, fwd_b;

    int n_chk  = 0;
    int n_pass = 0;

    // {pc, ifid, idex, exmem stall, ifid, idex, memwb flush}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LU    = 7'b1100010;
    localparam logic [6:0] C_REDIR = 7'b0000110;
    localparam logic [6:0] C_MEM   = 7'b1111001;
    localparam logic [6:0] C_ERR   = 7'b0000001;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .PERF_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ctrl();
        return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0; ex_redirect = 0;
        mem_rd = 0; mem_regwrite = 0; mem_access = 0; dmem_ready = 0;
        wb_rd = 0; wb_regwrite = 0;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        mem_regwrite = 1; mem_rd = 3; ex_rs1 = 3;
        ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        #3;
        chk("rst_ctrl", 32'(ctrl()), 32'(C_NONE));
        chk("rst_fwd_a", 32'(fwd_a), 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        tick();
        rstn = 1'b1;
        idle();
        tick();

        // load-use bubble, then the consumer forwards from EX/MEM
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1 chk("lu_ctrl", 32'(ctrl()), 32'(C_LU));
        tick();
        idle();
        mem_rd = 5; mem_regwrite = 1; ex_rs1 = 5;
        #1 chk("lu_after_ctrl", 32'(ctrl()), 32'(C_NONE));
        chk("lu_fwd_a", 32'(fwd_a), 32'h2);
        tick();

        idle();
        ex_memread = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 1;
        #1 chk("lu_rs2_ctrl", 32'(ctrl()), 32'(C_LU));
        id_use_rs2 = 0;
        #1 chk("lu_nouse_ctrl", 32'(ctrl()), 32'(C_NONE));
        ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        #1 chk("lu_x0_ctrl", 32'(ctrl()), 32'(C_NONE));
        ex_rd = 6; id_rs2 = 6; ex_redirect = 1;
        #1 chk("redir_lu_ctrl", 32'(ctrl()), 32'(C_REDIR));
        tick();

        idle();
        mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1; ex_rs2 = 7;
        #1 chk("fwd_b_mem", 32'(fwd_b), 32'h2);
        chk("fwd_a_none", 32'(fwd_a), 32'h0);
        mem_regwrite = 0;
        #1 chk("fwd_b_wb", 32'(fwd_b), 32'h1);
        ex_rs1 = 7;
        #1 chk("fwd_a_wb", 32'(fwd_a), 32'h1);
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0; mem_regwrite = 1;
        #1 chk("fwd_x0_a", 32'(fwd_a), 32'h0);
        chk("fwd_x0_b", 32'(fwd_b), 32'h0);
        tick();

        // three wait cycles; a redirect arriving in the wait persists to release
        idle();
        mem_access = 1; mem_rd = 9; mem_regwrite = 1; ex_rs1 = 9;
        #1 chk("mw1_ctrl", 32'(ctrl()), 32'(C_MEM));
        chk("mw_fwd_a", 32'(fwd_a), 32'h2);
        tick();
        ex_redirect = 1;
        ex_memread = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
        #1 chk("mw2_ctrl", 32'(ctrl()), 32'(C_MEM));
        tick();
        #1 chk("mw3_ctrl", 32'(ctrl()), 32'(C_MEM));
        tick();
        dmem_ready = 1;
        #1 chk("mw_rel_ctrl", 32'(ctrl()), 32'(C_REDIR));
        chk("mw_rel_err", 32'(mem_err), 32'h0);
        tick();
        idle();
        #1 chk("mw_after_err", 32'(mem_err), 32'h0);

        // timeout: 5 stall cycles then one ERR cycle
        mem_access = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("tmo_stall%0d", i), 32'(ctrl()), 32'(C_MEM));
            tick();
        end
        dmem_ready = 1;
        #1 chk("tmo_err_ctrl", 32'(ctrl()), 32'(C_ERR));
        chk("tmo_err_pulse", 32'(mem_err), 32'h1);
        tick();
        idle();
        #1 chk("tmo_post_err", 32'(mem_err), 32'h0);
        mem_access = 1; dmem_ready = 1;
        #1 chk("tmo_run_ctrl", 32'(ctrl()), 32'(C_NONE));
        tick();

        // async reset in the middle of a wait
        idle();
        mem_access = 1;
        tick();
        #1 chk("rmw_stall", 32'(ctrl()), 32'(C_MEM));
        mem_regwrite = 1; mem_rd = 2; ex_rs2 = 2;
        #1 rstn = 1'b0;
        #1 chk("rmw_ctrl", 32'(ctrl()), 32'(C_NONE));
        chk("rmw_fwd_b", 32'(fwd_b), 32'h0);
        chk("rmw_err", 32'(mem_err), 32'h0);
        tick();
        rstn = 1'b1;
        dmem_ready = 1;
        #1 chk("rmw_zero_wait", 32'(ctrl()), 32'(C_NONE));
        chk("rmw_fwd_b_on", 32'(fwd_b), 32'h2);
        tick();
        dmem_ready = 0;
        #1 chk("rmw_miss", 32'(ctrl()), 32'(C_MEM));
        tick();
        #1 chk("rmw_post_err", 32'(mem_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Consumes decoded control bits carried in the pipeline registers (RegWrite, MemRead, register indices) and EX-stage redirect.
- Consumes the data-memory ready handshake.
- Drives per-stage stall/flush enables and EX operand forwarding selects.
- Owns the data-memory wait-state FSM with timeout.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles in MWAIT before abort; legal range 1..255.
- PERF_W, 32: width of performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch / jal / jalr
- mem_rd  in  5  destination register of the instruction in MEM
- mem_regwrite  in  1  MEM instruction writes a register
- mem_access  in  1  MEM instruction is a load or store
- dmem_ready  in  1  data memory completes this cycle
- wb_rd  in  5  destination register of the instruction in WB
- wb_regwrite  in  1  WB instruction writes a register
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the stage register
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (NOP) into the stage register
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (rstn low, async): FSM = RUN, wait counter = 0, mem_err = 0. All stall/flush outputs and fwd selects read 0 while rstn is low.
- Stall/flush/fwd outputs are combinational from the current inputs plus the registered FSM state. mem_err is registered.
- FSM states and transitions:
  - RUN, mem_access & dmem_ready: zero-wait, stay RUN, no memory stall.
  - RUN, mem_access & !dmem_ready: assert memory stall this cycle, go to MWAIT, counter <= 1.
  - MWAIT, dmem_ready: no memory stall this cycle (instruction advances), go to RUN, counter <= 0.
  - MWAIT, !dmem_ready, counter < MEM_TIMEOUT: memory stall, counter++.
  - MWAIT, !dmem_ready, counter == MEM_TIMEOUT: go to ERR. Memory stall still asserted this cycle.
  - ERR (exactly one cycle): mem_err = 1, no stall, memwb_flush = 1 (the timed-out instruction is dropped), next state RUN. A late dmem_ready in ERR is ignored.
- Memory stall (RUN-miss or MWAIT-not-ready):
  - pc_stall = ifid_stall = idex_stall = exmem_stall = 1, memwb_flush = 1.
  - ifid_flush = idex_flush = 0.
  - Redirect and load-use are suppressed. EX is frozen, so ex_redirect persists and acts after release.
- Load-use, only when there is no memory stall and no redirect:
  - Condition: ex_memread & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Response: pc_stall = ifid_stall = 1, idex_flush = 1. Exactly one bubble per load.
- Redirect, when there is no memory stall: ifid_flush = idex_flush = 1, no stalls. Redirect has priority over load-use because the ID instruction is wrong-path.
- Forwarding, evaluated for rs1 → fwd_a and rs2 → fwd_b:
  - 10 if mem_regwrite & mem_rd != 0 & mem_rd == ex_rsN.
  - else 01 if wb_regwrite & wb_rd != 0 & wb_rd == ex_rsN.
  - else 00.
  - MEM beats WB on an equal register. Register x0 is never forwarded.
  - Forwarding remains valid during stalls.
- Reset mid-MWAIT: immediate return to RUN, counter cleared, no mem_err pulse.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_cyc, perf_lu_cnt, perf_flush_cnt (each PERF_W bits, reset 0, wrap at 2^PERF_W).
  - perf_stall_cyc increments each memory-stall cycle.
  - perf_lu_cnt increments each load-use bubble.
  - perf_flush_cnt increments each redirect flush.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- lw x5 in EX (ex_memread=1, ex_rd=5), ID add reads x5 (id_rs1=5, id_use_rs1=1) -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle; next cycle mem_rd=5, mem_regwrite=1, ex_rs1=5 -> fwd_a=10.
- ex_redirect=1 together with a load-use condition -> ifid_flush=idex_flush=1, pc_stall=0.
- mem_access=1, dmem_ready low for 3 cycles then high -> 3 cycles with all four stalls and memwb_flush at 1; release on the ready cycle; mem_err stays 0.
- MEM_TIMEOUT=4, dmem_ready never asserted -> 5 stall cycles, then one ERR cycle with mem_err=1, memwb_flush=1, then RUN.
- mem_rd=wb_rd=7, both regwrite, ex_rs2=7 -> fwd_b=10; all indices 0 -> fwd_a=fwd_b=00.
- rstn pulled low in MWAIT -> all outputs 0 immediately; after release, FSM is in RUN and a zero-wait access causes no stall.
